// File: rtl/audio_framer.sv
// Circular-buffer framer: collects PCM samples and streams overlapping frames of
// FRAME_LEN samples advancing by HOP, closing each utterance with a zero-padded frame.
module audio_framer #(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 256,
   parameter int HOP       = 128,
   parameter int DEPTH     = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sof,
   output logic              out_eof,
   output logic              out_utt_last,
   output logic              overflow,
   output logic [15:0]       frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int IW = $clog2(FRAME_LEN) + 1;

   typedef enum logic {IDLE, READ} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, frame_base, end_ptr;
   logic [PW-1:0]     fill, remain;
   logic              utt_pend, mode_final;
   logic              wr_en;

   logic [IW-1:0]     rd_idx_p0;
   logic [AW-1:0]     rd_addr_p0;
   logic              issue_p0, pad_p0;

   logic [DATA_W-1:0] rd_data_p1;
   logic              vld_p1, pad_p1, sof_p1, eof_p1;

   logic              out_free, move_p1, frame_done;
   logic              start_normal, start_final, drop_utt, reading;

   // fill is modular; pointers carry one extra bit so a full buffer reads as DEPTH
   assign fill   = wr_ptr - frame_base;
   assign remain = end_ptr - frame_base;
   assign wr_en  = in_valid && (fill != PW'(DEPTH));

   assign out_free   = !out_valid || out_ready;
   assign move_p1    = vld_p1 && out_free;
   assign frame_done = out_valid && out_ready && out_eof;

   assign issue_p0   = reading && (rd_idx_p0 < IW'(FRAME_LEN)) && (!vld_p1 || move_p1);
   assign rd_addr_p0 = frame_base[AW-1:0] + AW'(rd_idx_p0);
   assign pad_p0     = mode_final && (PW'(rd_idx_p0) >= remain);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (fill >= PW'(FRAME_LEN) || (utt_pend && remain != '0)) state_nxt = READ;
         READ: if (frame_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // complete frames win over the final padded frame
   always_comb begin
      start_normal = 1'b0;
      start_final  = 1'b0;
      drop_utt     = 1'b0;
      reading      = 1'b0;
      case (state)
         IDLE: begin
            if (fill >= PW'(FRAME_LEN))    start_normal = 1'b1;
            else if (utt_pend) begin
               if (remain != '0)           start_final  = 1'b1;
               else                        drop_utt     = 1'b1;
            end
         end
         READ:    reading = 1'b1;
         default: reading = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         frame_base  <= '0;
         end_ptr     <= '0;
         utt_pend    <= 1'b0;
         overflow    <= 1'b0;
         mode_final  <= 1'b0;
         rd_idx_p0   <= '0;
         frame_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (in_valid && !wr_en) overflow <= 1'b1;
         if (in_valid && in_last) begin
            if (!utt_pend) begin
               end_ptr  <= wr_ptr + PW'(wr_en);
               utt_pend <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end
         if (start_normal || start_final) begin
            mode_final <= start_final;
            rd_idx_p0  <= '0;
         end else if (issue_p0) begin
            rd_idx_p0  <= rd_idx_p0 + IW'(1);
         end
         if (drop_utt) utt_pend <= 1'b0;
         if (frame_done) begin
            frame_count <= frame_count + 16'd1;
            if (mode_final) begin
               frame_base <= end_ptr;
               utt_pend   <= 1'b0;
            end else begin
               frame_base <= frame_base + PW'(HOP);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
   end

   // ---- p0 -> p1: synchronous RAM read, flags travel with the sample
   always_ff @(posedge clk) begin
      if (issue_p0) begin
         rd_data_p1 <= mem[rd_addr_p0];
         pad_p1     <= pad_p0;
         sof_p1     <= (rd_idx_p0 == '0);
         eof_p1     <= (rd_idx_p0 == IW'(FRAME_LEN - 1));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         vld_p1 <= 1'b0;
      else if (issue_p0) vld_p1 <= 1'b1;
      else if (move_p1)  vld_p1 <= 1'b0;
   end

   // ---- p1 -> output register, held while the consumer stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sof      <= 1'b0;
         out_eof      <= 1'b0;
         out_utt_last <= 1'b0;
      end else if (out_free) begin
         out_valid    <= vld_p1;
         out_sof      <= vld_p1 && sof_p1;
         out_eof      <= vld_p1 && eof_p1;
         out_utt_last <= vld_p1 && eof_p1 && mode_final;
         if (vld_p1) out_data <= pad_p1 ? '0 : rd_data_p1;
      end
   end

endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer with FRAME_LEN=8, HOP=4, DEPTH=16.
module tb_audio_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sof;
   logic        out_eof;
   logic        out_utt_last;
   logic        overflow;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eof;
      logic        ul;
      logic [31:0] cyc;
   } beat_t;

   beat_t       q[$];
   logic [31:0] cyc = 0;

   audio_framer #(.DATA_W(16), .FRAME_LEN(8), .HOP(4), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
      .out_eof(out_eof), .out_utt_last(out_utt_last), .overflow(overflow),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // accepted beats, sampled mid-cycle ahead of the edge that transfers them
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready)
         q.push_back('{data: out_data, sof: out_sof, eof: out_eof, ul: out_utt_last, cyc: cyc});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      step();
      step();
      reset = 1'b0;
      q.delete();
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && q.size() < n; i++) step();
      check(tag, (q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_frame(input int qi, input int first, input int nvalid, input logic ul);
      for (int i = 0; i < 8; i++) begin
         if (qi + i >= q.size()) begin
            check("frame_missing", q.size(), qi + i + 1);
         end else begin
            check($sformatf("data[%0d]", qi + i), q[qi+i].data, (i < nvalid) ? first + i : 0);
            check($sformatf("sof[%0d]", qi + i), q[qi+i].sof, (i == 0) ? 1 : 0);
            check($sformatf("eof[%0d]", qi + i), q[qi+i].eof, (i == 7) ? 1 : 0);
            check($sformatf("utt[%0d]", qi + i), q[qi+i].ul, (ul && i == 7) ? 1 : 0);
         end
      end
   endtask

   initial begin
      out_ready = 1'b1;
      do_reset();

      // reset state
      check("rst_valid", out_valid, 0);
      check("rst_sof", out_sof, 0);
      check("rst_eof", out_eof, 0);
      check("rst_utt", out_utt_last, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", out_data, 0);
      check("rst_count", frame_count, 0);

      // two overlapping frames at full rate
      for (int s = 1; s <= 12; s++) send(16'(s), 1'b0);
      wait_beats("t1_beats", 16, 100);
      check_frame(0, 1, 8, 1'b0);
      check_frame(8, 5, 8, 1'b0);
      if (q.size() >= 8) check("t1_rate", q[7].cyc - q[0].cyc, 7);
      step();
      check("t1_count", frame_count, 2);
      check("t1_ovf", overflow, 0);

      // utterance ending mid-frame
      do_reset();
      for (int s = 1; s <= 10; s++) send(16'(s), s == 10);
      wait_beats("t2_beats", 16, 100);
      check_frame(0, 1, 8, 1'b0);
      check_frame(8, 5, 6, 1'b1);
      for (int i = 0; i < 20; i++) step();
      check("t2_count", frame_count, 2);
      check("t2_no_extra", q.size(), 16);

      // stalled consumer, buffer overfill
      do_reset();
      out_ready = 1'b0;
      for (int s = 1; s <= 8; s++) send(16'(s), 1'b0);
      for (int i = 0; i < 3 && !out_valid; i++) step();
      check("t3_latency", out_valid, 1);
      for (int c = 0; c < 20; c++) begin
         if (c < 9) send(16'(9 + c), 1'b0);
         else       step();
         check("t3_valid", out_valid, 1);
         check("t3_data", out_data, 1);
         check("t3_sof", out_sof, 1);
         if (c == 7) check("t3_ovf16", overflow, 0);
         if (c == 8) check("t3_ovf17", overflow, 1);
      end
      out_ready = 1'b1;
      wait_beats("t3_beats", 8, 50);
      check_frame(0, 1, 8, 1'b0);
      check("t3_ovf_sticky", overflow, 1);

      // slow stream with toggling ready, pointers wrap twice
      do_reset();
      begin
         int sent = 0;
         for (int c = 0; c < 800 && q.size() < 72; c++) begin
            out_ready = (c % 2 == 0);
            if (c % 8 == 0 && sent < 40) begin
               sent++;
               in_data  = 16'(sent);
               in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      check("t4_beats", q.size(), 72);
      for (int k = 0; k < 9; k++) check_frame(8 * k, 1 + 4 * k, 8, 1'b0);
      for (int i = 0; i < 10; i++) step();
      check("t4_count", frame_count, 9);
      check("t4_ovf", overflow, 0);

      // in_last on the sample that completes the first frame
      do_reset();
      for (int s = 1; s <= 8; s++) send(16'(s), s == 8);
      wait_beats("t5_beats", 16, 100);
      check_frame(0, 1, 8, 1'b0);
      check_frame(8, 5, 4, 1'b1);
      in_last = 1'b1;
      step();
      in_last = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("t5_no_extra", q.size(), 16);
      check("t5_count", frame_count, 2);
      check("t5_ovf", overflow, 0);

      // reset in the middle of a frame
      do_reset();
      for (int s = 1; s <= 8; s++) send(16'(s), 1'b0);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_data == 16'd4) seen = 1'b1;
         end
         check("t6_reach_idx3", seen, 1);
      end
      #2 reset = 1'b1;
      #1;
      check("t6_valid", out_valid, 0);
      check("t6_data", out_data, 0);
      check("t6_sof", out_sof, 0);
      check("t6_eof", out_eof, 0);
      check("t6_count", frame_count, 0);
      step();
      reset = 1'b0;
      q.delete();
      for (int s = 101; s <= 108; s++) send(16'(s), 1'b0);
      wait_beats("t6_beats", 8, 50);
      check_frame(0, 101, 8, 1'b0);
      step();
      check("t6_count_after", frame_count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
